// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response and decode handshake.
// misaligned exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface instr_fetch_unit_if;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;

    modport master (
        input  PCSrc, ImmExt, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        output misaligned
    );
    modport slave (
        output PCSrc, ImmExt, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  misaligned
    );
`else
    modport master (
        input  PCSrc, ImmExt, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr, instr_pc, instr_valid
    );
    modport slave (
        output PCSrc, ImmExt, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid
    );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// Stallable fetch stage: PC register, one outstanding imem request, valid/ready out.
// Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n,
    instr_fetch_unit_if.master bus
);
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] next_pc;
    logic        req;
    logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    // Branch target is relative to the presented instruction, not the live PC
    assign next_pc = instr_pc + (bus.PCSrc ? bus.ImmExt : 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req      <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
            valid    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ready) begin
                        instr    <= bus.imem_rdata;
                        instr_pc <= pc;
                        valid    <= 1'b1;
                        req      <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                            state      <= TRAP;
                        end else begin
                            pc    <= next_pc;
                            req   <= 1'b1;
                            state <= FETCH;
                        end
`else
                        pc    <= {next_pc[31:2], 2'b00};
                        req   <= 1'b1;
                        state <= FETCH;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                TRAP: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misaligned  = misaligned;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: PC model queue plus fetched-word queue.
// Build with FETCH_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_cyc = 0;

    logic [31:0] addr_q[$];
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] cur_pc;
    logic [31:0] cur_word;
    logic        trap_exp = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'b0, bus.imem_req}, 32'd1);
        if (addr_q.size() == 0) begin
            chk("addr_q_empty", 32'd1, 32'd0);
            exp_pc = 32'hDEAD_BEEF;
        end else begin
            exp_pc = addr_q.pop_front();
        end
        chk("imem_addr", bus.imem_addr, exp_pc);
    endtask

    task automatic respond(input int delay);
        for (int i = 0; i < delay; i++) begin
            bus.imem_ready = 1'b0;
            @(negedge clk);
            chk("req_held", {31'b0, bus.imem_req}, 32'd1);
            chk("addr_held", bus.imem_addr, exp_pc);
            chk("valid_lo", {31'b0, bus.instr_valid}, 32'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word_of(bus.imem_addr);
        sb_q.push_back({exp_pc, word_of(exp_pc)});
        @(negedge clk);
        valid_cyc = cyc;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        {cur_pc, cur_word} = sb_q.pop_front();
        chk("valid_hi", {31'b0, bus.instr_valid}, 32'd1);
        chk("req_lo", {31'b0, bus.imem_req}, 32'd0);
        chk("instr_pc", bus.instr_pc, cur_pc);
        chk("instr", bus.instr, cur_word);
    endtask

    task automatic accept(input int hold, input bit spurious,
                          input bit src, input logic [31:0] imm);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ready  = spurious && (i == 0);
            bus.imem_rdata  = ~cur_word;
            bus.PCSrc       = 1'($urandom);
            bus.ImmExt      = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("hold_instr", bus.instr, cur_word);
            chk("hold_pc", bus.instr_pc, cur_pc);
            chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
        end
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b1;
        bus.PCSrc       = src;
        bus.ImmExt      = imm;
        nxt = cur_pc + (src ? imm : 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_exp = (nxt[1:0] != 2'b00);
`else
        nxt[1:0] = 2'b00;
`endif
        if (!trap_exp) addr_q.push_back(nxt);
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.ImmExt      = '0;
        chk("acc_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("acc_req", {31'b0, bus.imem_req}, {31'b0, !trap_exp});
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, RST_PC);
        chk({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd0);
        chk({tag, "_instr"}, bus.instr, 32'd0);
        chk({tag, "_ipc"}, bus.instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_mis"}, {31'b0, bus.misaligned}, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.PCSrc       = 1'b0;
        bus.ImmExt      = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_vals("rst");

        rst_n = 1'b1;
        addr_q.push_back(RST_PC);
        chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);

        wait_req(); respond(0); t0 = valid_cyc;
        accept(0, 0, 0, 32'd0);
        wait_req(); respond(0);
        chk("tput", valid_cyc - t0, 32'd2);
        accept(0, 0, 0, 32'd0);
        wait_req(); respond(0);
        accept(0, 0, 1, 32'hFFFF_FFF8);

        wait_req(); respond(3);
        accept(5, 1, 0, 32'd0);
        wait_req(); respond(1);
        accept(0, 0, 0, 32'd0);
        wait_req(); respond(0);
        accept(0, 0, 0, 32'd0);
        wait_req(); respond(2);
        accept(1, 0, 1, 32'hFFFF_FEF0);
        wait_req(); respond(0);
        accept(0, 0, 0, 32'd0);
        wait_req(); respond(0);
        accept(0, 0, 1, 32'h200);

        wait_req();
        #2;
        rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        #1;
        reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        addr_q.delete();
        addr_q.push_back(RST_PC);
        reset_vals("rel");
        @(negedge clk);
        chk("restart_req", {31'b0, bus.imem_req}, 32'd1);

        wait_req(); respond(0);
        accept(0, 0, 1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            chk("trap_mis", {31'b0, bus.misaligned}, 32'd1);
            chk("trap_req", {31'b0, bus.imem_req}, 32'd0);
            chk("trap_valid", {31'b0, bus.instr_valid}, 32'd0);
            @(negedge clk);
        end
`else
        wait_req(); respond(0);
        accept(0, 0, 0, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch front end for the RISC-V core: holds the program counter, issues one request at a time to instruction memory, and presents each fetched instruction with its PC to the control/datapath through a valid/ready handshake. It consumes the control decoder's outputs: `PCSrc` and the sign-extended immediate select the next PC when the current instruction is accepted. This closes the loop between the decode/control path and instruction memory. It replaces the combinational PC+4/branch mux with a stallable, memory-latency-tolerant fetch stage.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: address of the first fetch after reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `PCSrc`  input  1  taken-branch/jump flag from control; sampled only on the accept handshake.
- `ImmExt`  input  32  sign-extended immediate for the presented instruction; sampled with `PCSrc`.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  32  fetch address; equals the PC register.
- `imem_ready`  input  1  memory response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  input  32  instruction word from memory.
- `instr`  output  32  registered instruction presented to decode.
- `instr_pc`  output  32  PC of `instr`.
- `instr_valid`  output  1  `instr`/`instr_pc` are valid.
- `instr_ready`  input  1  decode/execute accepts the presented instruction.
- `misaligned`  output  1  sticky misaligned-target flag; present only when `FETCH_MISALIGN_TRAP_EN` is defined.

## Operation
- States: `IDLE`, `FETCH`, `HOLD`, plus `TRAP` when the macro is defined.
- `IDLE`: entered on reset; unconditionally moves to `FETCH` on the next edge.
- `FETCH`: `imem_req`=1, and `imem_addr`=PC remains stable until `imem_ready`. On `imem_ready`, capture `instr`<=`imem_rdata` and `instr_pc`<=PC, set `instr_valid`=1, and go to `HOLD`.
- `HOLD`: `imem_req`=0. `instr`, `instr_pc` and `instr_valid` remain stable until `instr_ready`.
- Accept (`instr_valid & instr_ready`):
  - Next PC = `instr_pc + ImmExt` if `PCSrc`, otherwise `instr_pc + 4`.
  - Clear `instr_valid` and go to `FETCH`.
- Arithmetic: 32-bit add modulo 2^32; `32'hFFFF_FFFC + 4` wraps to `0`.
- `imem_ready` outside `FETCH` is ignored.
- `PCSrc` and `ImmExt` are ignored except on the accept cycle.
- Only one request is outstanding at a time; there is no prefetch.
- Reset mid-operation (any state):
  - Asynchronously return to `IDLE`; PC=`RESET_PC`.
  - An in-flight memory response is discarded.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `misaligned`=0.
- First request: `imem_req` rises one cycle after `rst_n` deasserts (the `IDLE` cycle).
- Fetch latency: `instr_valid` rises on the edge at which `imem_ready`=1 is sampled.
- Redirect latency: the new `imem_addr`/`imem_req` appear in the cycle after the accept edge.
- Throughput: with zero-wait memory (`imem_ready` in the first `FETCH` cycle) and `instr_ready` tied high, one instruction every 2 cycles.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - On accept with a computed next PC where `[1:0]`≠`2'b00`: go to `TRAP` and set `misaligned`=1.
  - In `TRAP`: `imem_req`=0 and `instr_valid`=0. The flag is sticky; only `rst_n` exits `TRAP`.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - No `TRAP` state and no `misaligned` port.
  - Next-PC bits `[1:0]` are forced to `2'b00` and fetch continues.

## Test plan
- Reset, `RESET_PC`=`32'h100`, zero-wait memory, `instr_ready`=1 -> `imem_addr` sequence `100`,`104`,`108`; `instr_valid` pulses every 2 cycles with the matching `instr_pc`.
- Memory delays `imem_ready` by 3 cycles -> `imem_req`/`imem_addr` held stable for 4 cycles; a spurious `imem_ready` during `HOLD` leaves `instr` unchanged.
- Accept with `PCSrc`=1, `ImmExt`=`32'hFFFF_FFF8` at `instr_pc`=`32'h108` -> next `imem_addr`=`32'h100`; with `PCSrc`=0 -> `32'h10C`.
- `instr_ready` low for 5 cycles -> `instr`/`instr_pc`/`instr_valid` stable and `imem_req`=0 throughout.
- `rst_n` pulsed low while in `FETCH` at `32'h200` -> outputs immediately return to reset values; fetch restarts at `RESET_PC` one cycle after release.
- With the macro: `PCSrc`=1, `ImmExt`=`32'h6` at `instr_pc`=`32'h100` -> `misaligned`=1, no further `imem_req`. Without the macro: same stimulus -> next `imem_addr`=`32'h104`.
